dcache_pmem_arb: RTL
====================

# dcache_pmem_arb

Two-requester arbiter driving `select_i` of `dcache_pmem_mux`; shares the data cache's single pmem port between requester 0 (cache refill/writeback) and requester 1 (uncached/bypass path). Observes both requesters' command lines and the pmem handshake, grants one requester at a time, and holds the grant until every burst issued under it has fully drained. This guarantees the mux's one-cycle-delayed select still steers every ack and error to the correct requester.

## Interface
Parameters:
- `PENDING_W`, 10, width of outstanding-ack counter; must hold 2 full 256-beat read bursts.

Ports:
- `clk_i`  in  1  clock
- `rst_i`  in  1  reset, asynchronous, active-high
- `inport0_wr_i`  in  4  requester 0 write byte strobes
- `inport0_rd_i`  in  1  requester 0 read request
- `inport0_len_i`  in  8  requester 0 burst length − 1
- `inport1_wr_i`  in  4  requester 1 write byte strobes
- `inport1_rd_i`  in  1  requester 1 read request
- `inport1_len_i`  in  8  requester 1 burst length − 1
- `outport_accept_i`  in  1  pmem accepted current command/beat
- `outport_ack_i`  in  1  pmem response beat
- `outport_error_i`  in  1  error flag, valid only with `outport_ack_i`
- `select_o`  out  1  registered grant; drives mux `select_i`
- `busy_o`  out  1  high in BUSY state
- `pending_o`  out  `PENDING_W`  outstanding ack count

## Operation
- Owner = `select_o`. Owner request: `req_n = |inportN_wr_i | inportN_rd_i`.
- Accepted read: owner `rd` and `outport_accept_i` → pending += `len`+1.
- Accepted write beat: owner `wr != 0` and `outport_accept_i`. `beat_q` counts accepted beats of the current burst. When `beat_q == len`, the beat is the last one: pending += 1 and `beat_q` is cleared; otherwise `beat_q` += 1.
- Ack: `outport_ack_i` → pending −= 1. Error-acks count the same. Accept and ack in the same cycle apply both: net = add − 1.
- Overflow beyond 2^`PENDING_W`−1 is illegal requester behaviour. Counter wraps; the simulation assertion fires.
- States:
  - IDLE: arbitrate.
    - Winner == owner and owner's command accepted → BUSY.
    - Winner != owner → flip `select_o` next edge and stay IDLE (one bubble cycle; the mux gates accept to the non-owner meanwhile).
    - No request → hold `select_o`.
  - BUSY: `select_o` frozen. Owner may issue further bursts; they are counted.
    - Return to IDLE when pending == 0, `beat_q` == 0, owner `req` low, and no accept this cycle.
- An ack arriving in IDLE with pending == 0 is ignored (counter saturates at 0) and flagged by the assertion.

## Timing
- Reset values: `select_o`=0, `busy_o`=0, `pending_o`=0. State IDLE, `beat_q`=0, RR pointer=0 (last served = 0).
- `select_o` and `busy_o` are registered, with no combinational input→output path.
- Switch latency: non-owner request in cycle t (owner idle) → `select_o` flips at t+1 → earliest accept at t+1.
- Release: last ack in cycle t → IDLE at t+1 → `select_o` may flip at t+2. The mux's `select_q` therefore still equals owner during the last ack.
- Reset mid-burst: all state cleared immediately. Pmem-side cleanup is the system's responsibility.

## Configuration
- `DCACHE_PMEM_ARB_RR_EN` defined: round-robin. When both request in IDLE, the requester not served last wins. The pointer updates on IDLE→BUSY.
- Undefined: fixed priority, requester 0 (refill) always wins ties. RR pointer logic is not compiled.

## Test plan
- Reset, idle: `select_o`=0, `busy_o`=0, `pending_o`=0. Ack pulse with pending 0 → counter stays 0, assertion fires.
- Requester 1 read, `len`=7, owner 0 → `select_o`=1 next cycle. Accept → `pending_o`=8, `busy_o`=1. After 8 acks → IDLE one cycle later.
- Requester 0 write burst `len`=3, 4 beats accepted with gaps → pending reaches 1 only on 4th beat. Requester 1 asserting `rd` throughout is not granted until after the write ack.
- Accept of a second read (`len`=0) in the same cycle as an ack of the first (pending 2) → pending stays 2.
- Both request continuously, `DCACHE_PMEM_ARB_RR_EN` defined → grants alternate 0,1,0,1. Without the macro → requester 0 is granted every time.
- `rst_i` asserted with pending 5 → all outputs at reset values same cycle. After release, a new requester 1 read is granted normally.

Source files
------------

// File: rtl/dcache_pmem_arb.sv
// Two-requester grant for the data cache's shared pmem port.
// Holds the grant until every burst issued under it has drained.
// Build option: DCACHE_PMEM_ARB_RR_EN selects round-robin, otherwise requester 0 wins ties.
module dcache_pmem_arb #(
  parameter int PENDING_W = 10
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [3:0]           inport0_wr_i,
  input  logic                 inport0_rd_i,
  input  logic [7:0]           inport0_len_i,
  input  logic [3:0]           inport1_wr_i,
  input  logic                 inport1_rd_i,
  input  logic [7:0]           inport1_len_i,
  input  logic                 outport_accept_i,
  input  logic                 outport_ack_i,
  input  logic                 outport_error_i,
  output logic                 select_o,
  output logic                 busy_o,
  output logic [PENDING_W-1:0] pending_o
);

  localparam logic STATE_IDLE = 1'b0;
  localparam logic STATE_BUSY = 1'b1;

  logic                 state_reg, state_next;
  logic                 select_reg, select_next;
  logic [PENDING_W-1:0] pending_reg, pending_next;
  logic [7:0]           beat_reg, beat_next;

  logic       req0, req1, any_req, own_req, own_rd, winner;
  logic [3:0] own_wr;
  logic [7:0] own_len;
  logic       rd_acc, wr_acc, ack_dec, overflow;
  logic [PENDING_W:0] add_val, sum_val;

  assign req0    = (|inport0_wr_i) | inport0_rd_i;
  assign req1    = (|inport1_wr_i) | inport1_rd_i;
  assign any_req = req0 | req1;
  assign own_req = select_reg ? req1 : req0;
  assign own_rd  = select_reg ? inport1_rd_i  : inport0_rd_i;
  assign own_wr  = select_reg ? inport1_wr_i  : inport0_wr_i;
  assign own_len = select_reg ? inport1_len_i : inport0_len_i;

  // The mux only forwards the owner's command, so any accept belongs to the owner.
  assign rd_acc = own_rd & outport_accept_i;
  assign wr_acc = ~own_rd & (|own_wr) & outport_accept_i;

  // Error acks retire a beat exactly like normal acks; the flag itself is not needed here.
  assign ack_dec = outport_ack_i & (pending_reg != '0);

`ifdef DCACHE_PMEM_ARB_RR_EN
  logic last_reg, last_next;
  assign winner = (req0 & req1) ? ~last_reg : req1;
`else
  assign winner = req1 & ~req0;
`endif

  always_comb begin
    add_val   = '0;
    beat_next = beat_reg;
    if (rd_acc) begin
      add_val = (PENDING_W+1)'(own_len) + (PENDING_W+1)'(1);
    end else if (wr_acc) begin
      if (beat_reg == own_len) begin
        add_val   = (PENDING_W+1)'(1);
        beat_next = 8'd0;
      end else begin
        beat_next = beat_reg + 8'd1;
      end
    end
  end

  assign sum_val      = {1'b0, pending_reg} + add_val - (PENDING_W+1)'(ack_dec);
  assign overflow     = sum_val[PENDING_W];
  assign pending_next = sum_val[PENDING_W-1:0];

  always_comb begin
    state_next  = state_reg;
    select_next = select_reg;
`ifdef DCACHE_PMEM_ARB_RR_EN
    last_next   = last_reg;
`endif
    case (state_reg)
      STATE_IDLE: begin
        // An accepted owner command always commits the grant, even if the other side now wins.
        if (own_req && outport_accept_i) begin
          state_next = STATE_BUSY;
`ifdef DCACHE_PMEM_ARB_RR_EN
          last_next  = select_reg;
`endif
        end else if (any_req && (winner != select_reg)) begin
          select_next = winner;
        end
      end
      default: begin
        // Leave as the last ack retires so select is still correct during that ack.
        if ((pending_next == '0) && (beat_reg == 8'd0) && !own_req && !outport_accept_i)
          state_next = STATE_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_reg   <= STATE_IDLE;
      select_reg  <= 1'b0;
      pending_reg <= '0;
      beat_reg    <= 8'd0;
    end else begin
      state_reg   <= state_next;
      select_reg  <= select_next;
      pending_reg <= pending_next;
      beat_reg    <= beat_next;
    end
  end

`ifdef DCACHE_PMEM_ARB_RR_EN
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) last_reg <= 1'b0;
    else       last_reg <= last_next;
  end
`endif

  assign select_o  = select_reg;
  assign busy_o    = (state_reg == STATE_BUSY);
  assign pending_o = pending_reg;

  always @(posedge clk_i) begin
    if (!rst_i) begin
      assert (!(outport_ack_i && (pending_reg == '0)))
        else $warning("dcache_pmem_arb: ack with nothing outstanding");
      assert (!overflow);
    end
  end

endmodule
